// File: rtl/disp_pkg.sv
// Shared types, constants and the 16-bit saturation helper for the display scheduler.
package disp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } disp_state_t;

  localparam int unsigned NUM_W = 16;
  localparam logic [NUM_W-1:0] MAX_NUM = 16'd9999;

  function automatic logic [NUM_W-1:0] sat_num(input logic [NUM_W-1:0] v);
    return (v > MAX_NUM) ? MAX_NUM : v;
  endfunction

endpackage

// File: rtl/disp_hold_tmr.sv
// Loadable down-counter timing the minimum on-screen hold; zero flags expiry.
module disp_hold_tmr #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/disp_sched.sv
// Round-robin display scheduler with minimum hold feeding seg_driver.
// Optional macro DISP_SCHED_PRIO_EN: requester 0 wins always and preempts other holds.
module disp_sched
    import disp_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned HOLD_CYC = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*NUM_W-1:0]   num_in,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic [NUM_W-1:0]         num_out,
    output logic                     strobe,
    output logic                     busy
);

    localparam int unsigned OW    = $clog2(N_REQ);
    localparam int unsigned CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [OW-1:0]    OWNER_RST = OW'(N_REQ - 1);

    disp_state_t state, state_nxt;

    logic [NUM_W-1:0] vals [N_REQ];
    logic [NUM_W-1:0] win_val, own_val, num_nxt;
    logic [OW-1:0]    win, owner_nxt, idx;
    logic [N_REQ-1:0] gnt_nxt;
    logic             win_vld, hold_zero, prio_pre, rearb, arb;
    logic             strobe_nxt, busy_nxt, tmr_load, tmr_en;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign vals[g] = num_in[g*NUM_W +: NUM_W];
    end

    // Search starts just past the owner so the current owner is considered last.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        idx     = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = OW'((32'(owner) + i) % N_REQ);
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
`ifdef DISP_SCHED_PRIO_EN
        if (req[0]) begin
            win_vld = 1'b1;
            win     = '0;
        end
`endif
    end

`ifdef DISP_SCHED_PRIO_EN
    assign prio_pre = req[0] && (owner != '0);
`else
    assign prio_pre = 1'b0;
`endif

    assign win_val = sat_num(vals[win]);
    assign own_val = sat_num(vals[owner]);
    assign rearb   = (state == HOLD) && (hold_zero || !req[owner] || prio_pre);
    assign arb     = (state == IDLE) || rearb;

    disp_hold_tmr #(
        .CNT_W(CNT_W)
    ) u_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (HOLD_LOAD),
        .zero     (hold_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = HOLD;
            HOLD:    if (rearb && !win_vld) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt    = gnt;
        owner_nxt  = owner;
        num_nxt    = num_out;
        busy_nxt   = busy;
        strobe_nxt = 1'b0;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        if (arb) begin
            if (win_vld) begin
                owner_nxt      = win;
                gnt_nxt        = '0;
                gnt_nxt[win]   = 1'b1;
                num_nxt        = win_val;
                busy_nxt       = 1'b1;
                tmr_load       = 1'b1;
                strobe_nxt     = (win != owner) || (state == IDLE) || (win_val != num_out);
            end else begin
                gnt_nxt  = '0;
                busy_nxt = 1'b0;
            end
        end else begin
            tmr_en = 1'b1;
            if (own_val != num_out) begin
                num_nxt    = own_val;
                strobe_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt     <= '0;
            owner   <= OWNER_RST;
            num_out <= '0;
            strobe  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            gnt     <= gnt_nxt;
            owner   <= owner_nxt;
            num_out <= num_nxt;
            strobe  <= strobe_nxt;
            busy    <= busy_nxt;
        end
    end

endmodule

// File: doc/disp_sched.md
# disp_sched

Display scheduler that shares the single four-digit seven-segment driver (`seg_driver`) among several requesters, such as the encoder-adjusted setpoint, button-entered values and PWM duty readback. It runs a round-robin grant with a minimum on-screen hold time. It presents one saturated 16-bit value plus an update strobe to `seg_driver`, and sits between the value producers and the display in the top level.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `HOLD_CYC`, default 1000: minimum grant duration in clk cycles, ≥1.
- `clk`  in  1: single clock; all logic on posedge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `req`  in  N_REQ: request per requester, level-sensitive.
- `num_in`  in  N_REQ×16: packed values, requester i at bits [16i+15:16i].
- `gnt`  out  N_REQ: one-hot grant, zero when idle.
- `owner`  out  $clog2(N_REQ): index of current or last owner.
- `num_out`  out  16: value to `seg_driver.num`, saturated to ≤9999.
- `strobe`  out  1: one-cycle pulse when `num_out` is loaded or changed.
- `busy`  out  1: high while in HOLD.

## Operation
- All outputs are registered.
- Reset values:
  - `gnt`=0, `owner`=N_REQ-1, `num_out`=0, `strobe`=0, `busy`=0, state IDLE.
  - The round-robin pointer is reset to N_REQ-1, so requester 0 wins first.
- States:
  - IDLE: `gnt`=0. If any `req` is set, arbitrate (see below), then go to HOLD. Otherwise stay.
  - HOLD: `hold_cnt` decrements each cycle. The state is re-arbitrated when `hold_cnt`==0 or when `req[owner]` deasserts.
- Arbitration:
  - The winner is the first set `req` bit searching from `owner`+1 mod N_REQ and wrapping around. The current owner is considered last.
  - On a win: `owner`←w, `gnt`←onehot(w), `num_out`←sat(`num_in`[w]), `hold_cnt`←HOLD_CYC-1, state HOLD.
  - `strobe`←1 if the winner differs from the old owner, if coming from IDLE, or if the value differs from `num_out`.
  - If there is no winner: go to IDLE. `gnt`←0, `busy`←0, and `num_out` keeps its last value (the display freezes).
- Live update: in HOLD with no re-arbitration, if sat(`num_in`[owner]) ≠ `num_out`, then `num_out` is updated and `strobe`←1 for one cycle. Otherwise `strobe`←0.
- Saturation: any value >9999 maps to 9999. The comparison is unsigned on 16 bits.
- Sole requester: if the owner is still requesting at hold expiry and no one else is, it is re-granted. `gnt` does not glitch, and the hold reloads.
- Simultaneous owner drop and expiry: treated as a single re-arbitration.
- Reset mid-HOLD: all outputs return to reset values asynchronously.

## Timing
- `req` rising in IDLE at edge k produces `gnt`, `busy`, `num_out` and `strobe` valid after edge k+1. Latency is 1 cycle.
- A grant lasts exactly HOLD_CYC cycles while contended. The switch to the next owner is visible on cycle HOLD_CYC+1 after the grant.
- Owner drop: `gnt` moves or clears 1 cycle after `req[owner]` falls.
- `num_in` change by the owner: `num_out` and `strobe` update 1 cycle later.
- `strobe` is never high for two consecutive cycles unless the value changes on consecutive cycles.

## Configuration
- `DISP_SCHED_PRIO_EN` defined: requester 0 is high priority.
  - In arbitration it wins whenever `req[0]` is set, regardless of the pointer.
  - In HOLD with another owner, `req[0]` rising preempts: the re-arbitration happens immediately, without waiting for `hold_cnt`.
  - The owner 0 hold is not preemptible.
- Undefined: pure round-robin, and no requester can cut a hold short.

## Structure
- Shared package `disp_pkg` contains:
  - state enum `disp_state_t` {IDLE, HOLD};
  - `NUM_W`=16;
  - `MAX_NUM`=9999;
  - the saturation function `sat_num`.
- One sub-module, `disp_hold_tmr`: a loadable down-counter with load, enable, `zero` flag, and width $clog2(HOLD_CYC). Arbitration stays in `disp_sched`.

## Test plan
1. **Single grant.** HOLD_CYC=4, `req`=0010, `num_in`[1]=1234 → one cycle later `gnt`=0010, `owner`=1, `num_out`=1234, `strobe` pulses once, `busy`=1.
2. **Round-robin.** `req`=0101 held, values 11 and 22 → `gnt`=0001 for 4 cycles, then 0100 for 4 cycles, then 0001. `strobe` pulses at each switch with `num_out` 11, 22, 11.
3. **Live update and saturation.** The owner's `num_in` steps 15→16→12000 → `num_out` goes 16, then 9999, with one `strobe` per change. No strobe when the value is held.
4. **Release.** The sole owner drops `req` mid-hold → `gnt`=0 and `busy`=0 next cycle. `num_out` holds its last value and `strobe`=0.
5. **Preemption** (`DISP_SCHED_PRIO_EN`). Owner 2 at cycle 1 of its hold, `req[0]` rises → `gnt`=0001 next cycle. Without the macro, `gnt` stays 0100 until the hold expires.
6. **Reset mid-HOLD.** Assert `reset` asynchronously mid-HOLD → outputs immediately return to reset values. After release, `req`=1111 grants requester 0 first.
